presence_uart_reporter: RTL

//   Downstream consumer of the ultrasonic sensor's debounced object_detected level.

---
 rtl/presence_uart_reporter_pkg.sv | 27 ++
 rtl/presence_uart_reporter_uart_tx_8n1.sv | 54 +++++
 rtl/presence_uart_reporter.sv | 103 ++++++++++
 3 files changed

// File: rtl/presence_uart_reporter_pkg.sv
// rtl/presence_uart_reporter_pkg.sv - shared constants and helpers for the presence UART reporters
package presence_uart_reporter_pkg;

  localparam logic [7:0] ASCII_D  = 8'h44;
  localparam logic [7:0] ASCII_N  = 8'h4E;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND_STAT,
    ST_SEND_LF
  } msg_state_t;

  // Rounded divider so the bit period error stays within half a clock.
  function automatic int baud_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

  function automatic int hb_cycles(input int clk_freq, input int heartbeat_ms);
    return clk_freq / 1000 * heartbeat_ms;
  endfunction

  function automatic logic [7:0] status_byte(input logic level);
    return level ? ASCII_D : ASCII_N;
  endfunction

endpackage

// File: rtl/presence_uart_reporter_uart_tx_8n1.sv
// rtl/presence_uart_reporter_uart_tx_8n1.sv - 8N1 UART transmitter, LSB first, idle high
module uart_tx_8n1
  import presence_uart_reporter_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int DIV_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);

  logic [DIV_W-1:0] baud_cnt;
  logic [3:0]       bit_idx;
  logic [8:0]       shift;

  // bit_idx: 0 = start bit, 1..8 = data bits, 9 = stop bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= 4'd0;
      shift    <= '1;
    end else if (tx_ready) begin
      if (tx_start) begin
        tx       <= 1'b0;
        tx_ready <= 1'b0;
        baud_cnt <= '0;
        bit_idx  <= 4'd0;
        shift    <= {1'b1, tx_data};
      end
    end else if (baud_cnt == DIV_LAST) begin
      baud_cnt <= '0;
      if (bit_idx == 4'd9) begin
        tx_ready <= 1'b1;
      end else begin
        tx      <= shift[0];
        shift   <= {1'b1, shift[8:1]};
        bit_idx <= bit_idx + 4'd1;
      end
    end else begin
      baud_cnt <= baud_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/presence_uart_reporter.sv
// rtl/presence_uart_reporter.sv - reports debounced presence level to the RP2040 over UART
module presence_uart_reporter
  import presence_uart_reporter_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115_200,
  parameter int HEARTBEAT_MS = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        object_detected,
  output logic        uart_tx,
  output logic        tx_busy,
  output logic [15:0] event_count
);

  localparam int HB_CYCLES = hb_cycles(CLK_FREQ, HEARTBEAT_MS);
  localparam bit HB_EN     = (HEARTBEAT_MS > 0) && (HB_CYCLES > 0);
  localparam logic [31:0] HB_LAST = HB_EN ? 32'(HB_CYCLES - 1) : 32'd0;

  logic        sync_q1;
  logic        det_s;
  logic        det_d;
  logic        last_reported;
  logic [31:0] hb_cnt;
  logic        hb_expired;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_ready;
  msg_state_t  state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1     <= 1'b0;
      det_s       <= 1'b0;
      det_d       <= 1'b0;
      event_count <= 16'd0;
    end else begin
      sync_q1 <= object_detected;
      det_s   <= sync_q1;
      det_d   <= det_s;
      if (det_s && !det_d && (event_count != 16'hFFFF))
        event_count <= event_count + 16'd1;
    end
  end

  assign hb_expired = HB_EN && (hb_cnt == HB_LAST);

  // The LF byte is preloaded while the status byte is on the wire, so the core
  // picks it up one cycle after the status stop bit ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      last_reported <= 1'b0;
      tx_start      <= 1'b0;
      tx_data       <= ASCII_N;
      hb_cnt        <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if ((det_s != last_reported) || hb_expired) begin
            last_reported <= det_s;
            tx_data       <= status_byte(det_s);
            tx_start      <= 1'b1;
            hb_cnt        <= 32'd0;
            state         <= ST_SEND_STAT;
          end else if (HB_EN) begin
            hb_cnt <= hb_cnt + 32'd1;
          end
        end
        ST_SEND_STAT: begin
          if (tx_ready) begin
            tx_data <= ASCII_LF;
            state   <= ST_SEND_LF;
          end
        end
        ST_SEND_LF: begin
          if (tx_ready) begin
            if (tx_start) tx_start <= 1'b0;
            else          state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Busy covers the frames plus the single gap cycle between status and LF.
  assign tx_busy = ~tx_ready | ((state == ST_SEND_LF) & tx_start);

  uart_tx_8n1 #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) u_tx (
    .clk     (clk),
    .rst     (rst),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .tx      (uart_tx)
  );

endmodule
